// File: rtl/alu_ft_issue_seq_if.sv
// Operation, ALU-side and result handshake bundle for alu_ft_issue_seq.
// master is the sequencer's view; slave is the surrounding environment's view.
interface alu_ft_issue_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic        alu_run;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        alu_fault;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic        out_fault;

    modport master (
        input  in_valid, in_a, in_b, in_ctrl, alu_result, alu_flags, alu_fault, out_ready,
        output in_ready, alu_a, alu_b, alu_ctrl, alu_run, out_valid, out_result, out_flags,
               out_fault
    );

    modport slave (
        output in_valid, in_a, in_b, in_ctrl, alu_result, alu_flags, alu_fault, out_ready,
        input  in_ready, alu_a, alu_b, alu_ctrl, alu_run, out_valid, out_result, out_flags,
               out_fault
    );
endinterface

// File: rtl/alu_ft_issue_seq.sv
// Issue/retire sequencer for the time-redundant ALU: FIFO, held operands, 2/3-cycle retire.
// Optional saturating fault counter enabled by defining ALU_SEQ_FAULT_CNT_EN.
module alu_ft_issue_seq #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
`ifdef ALU_SEQ_FAULT_CNT_EN
    output logic [CNT_W-1:0] fault_cnt,
    input  logic             fault_cnt_clr,
`endif
    alu_ft_issue_seq_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FullCnt = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0] CntOne = 1;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
    } op_t;

    typedef enum logic [2:0] {StIdle, StEval1, StEval2, StVote, StRetire} state_t;

    op_t              mem [DEPTH];
    op_t              head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    state_t           state;
    logic             push;
    logic             pop;

    assign bus.in_ready = (count != FullCnt);
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = (state == StIdle) && (count != '0);
    assign head         = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: bus.in_a, b: bus.in_b, ctrl: bus.in_ctrl};
        end
    end

    // Pointers rely on DEPTH being a power of two to wrap for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CntOne;
            else if (pop && !push) count <= count - CntOne;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= StIdle;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_ctrl   <= '0;
            bus.alu_run    <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_flags  <= '0;
            bus.out_fault  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (pop) begin
                        bus.alu_a    <= head.a;
                        bus.alu_b    <= head.b;
                        bus.alu_ctrl <= head.ctrl;
                        bus.alu_run  <= 1'b1;
                        state        <= StEval1;
                    end
                end
                StEval1: state <= StEval2;
                StEval2: begin
                    // A fault here lets the ALU run its third (voting) stage.
                    if (bus.alu_fault) begin
                        state <= StVote;
                    end else begin
                        bus.out_result <= bus.alu_result;
                        bus.out_flags  <= bus.alu_flags;
                        bus.out_fault  <= 1'b0;
                        bus.out_valid  <= 1'b1;
                        bus.alu_run    <= 1'b0;
                        state          <= StRetire;
                    end
                end
                StVote: begin
                    bus.out_result <= bus.alu_result;
                    bus.out_flags  <= bus.alu_flags;
                    bus.out_fault  <= 1'b1;
                    bus.out_valid  <= 1'b1;
                    bus.alu_run    <= 1'b0;
                    state          <= StRetire;
                end
                StRetire: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef ALU_SEQ_FAULT_CNT_EN
    localparam logic [CNT_W-1:0] CntMax = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_cnt <= '0;
        end else if (fault_cnt_clr) begin
            fault_cnt <= '0;
        end else if (bus.out_valid && bus.out_ready && bus.out_fault && fault_cnt != CntMax) begin
            fault_cnt <= fault_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
